// File: rtl/dm_resp_pkg.sv
// Shared types and widths for the data-memory responder.
// Pure declarations, no logic and no latency.
// Backpressure: not applicable.
package dm_resp_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dm_state_e;

endpackage

// File: rtl/dm_byte_merge.sv
// Byte-lane merge of store data into an existing word.
// Purely combinational, zero latency.
// Backpressure: none, it is a function of its inputs.
module dm_byte_merge
  import dm_resp_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] merged
);

  // Each enabled lane takes the new byte; disabled lanes keep the old one.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder: one load/store per transaction, word-addressed store.
// Latency: rsp_valid rises LATENCY cycles after the accept cycle.
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready.
// Optional store log: define DM_RESP_WRITE_LOG_EN to print every store commit.
module dm_responder
  import dm_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [WORD_W-1:0]   req_addr,
  input  logic [BE_W-1:0]     req_be,
  input  logic [WORD_W-1:0]   req_wdata,
  input  logic [WORD_W-1:0]   req_pc,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORD_W-1:0]   rsp_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  if (LATENCY < 1) begin : g_bad_latency
    $error("dm_responder: LATENCY must be at least 1");
  end

  dm_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [WORD_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   pc_q, pc_d;
  logic [WORD_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic                mem_wr_en;
  logic [DEPTH_LOG2-1:0] mem_wr_idx;
  logic [WORD_W-1:0]   mem_wr_dat;

  // The commit source is the live request when committing on the accept edge
  // (LATENCY == 1), otherwise the latched copy.
  logic                cur_we;
  logic [WORD_W-1:0]   cur_addr;
  logic [BE_W-1:0]     cur_be;
  logic [WORD_W-1:0]   cur_wdata;
  logic [WORD_W-1:0]   cur_pc;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [WORD_W-1:0]   old_word;
  logic [WORD_W-1:0]   merged;
  logic                commit;

  // Select live or latched request fields and fetch the addressed word.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_be    = be_q;
    cur_wdata = wdata_q;
    cur_pc    = pc_q;
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_be    = req_be;
      cur_wdata = req_wdata;
      cur_pc    = req_pc;
    end
    cur_idx  = cur_addr[DEPTH_LOG2+1:2];
    old_word = mem_q[cur_idx];
  end

  dm_byte_merge u_merge (
    .old_word (old_word),
    .wdata    (cur_wdata),
    .be       (cur_be),
    .merged   (merged)
  );

  // Next-state logic: IDLE -> WAIT -> RESP -> IDLE, plus request latch and commit.
  // cnt_q counts the cycles still to go before rsp_valid; WAIT leaves at 1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    pc_d        = pc_q;
    rsp_rdata_d = rsp_rdata_q;
    commit      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          be_d    = req_be;
          wdata_d = req_wdata;
          pc_d    = req_pc;
          if (LATENCY == 1) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      rsp_rdata_d = cur_we ? merged : old_word;
    end

    mem_wr_en  = commit && cur_we;
    mem_wr_idx = cur_idx;
    mem_wr_dat = merged;
  end

  // Control and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      pc_q        <= pc_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Word store; cleared on reset so an aborted store can never land.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_wr_en) begin
      mem_q[mem_wr_idx] <= mem_wr_dat;
    end
  end

`ifdef DM_RESP_WRITE_LOG_EN
  // Store log, printed on the commit edge (zero byte-enable stores included).
  always_ff @(posedge clk) begin
    if (!reset && commit && cur_we) begin
      $display("%d@%h: *%h <= %h", $time, cur_pc, {cur_addr[31:2], 2'b00}, merged);
    end
  end
`endif

  // Address bits outside the word index and the PC are not used by the datapath.
  logic unused_ok;
  assign unused_ok = ^{cur_addr[WORD_W-1:DEPTH_LOG2+2], cur_addr[1:0], cur_pc};

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder with hand-computed expected values.
// Latency and handshake are checked on every transaction.
// Backpressure is exercised by holding rsp_ready low while a stray request is offered.
module tb_dm_responder;

  localparam int DL  = 10;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction. hold > 0 keeps rsp_ready low for that many cycles while
  // a stray store request is offered and must be ignored.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      input logic [31:0] exp, input int hold);
    int  n;
    bit  seen;
    @(negedge clk);
    check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
    req_pc    = 32'h0000_1000 + addr;
    @(posedge clk);
    #1;
    // Scramble every input after the accept edge; the latched copy must be used.
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = addr ^ 32'h0000_0010;
    req_be    = ~be;
    req_wdata = ~wd;
    n    = 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    check({tag, "/latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(LAT));
    check({tag, "/rdata"}, rsp_rdata, exp);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = addr;
      req_be    = 4'hF;
      req_wdata = 32'h0BAD_0BAD;
      @(posedge clk);
      @(negedge clk);
      check({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "/hold_rdata"}, rsp_rdata, exp);
      check({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "/rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "/back_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    // 1: reset state and first read
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst/req_ready", 32'(req_ready), 32'd1);
    check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst/rsp_rdata", rsp_rdata, 32'd0);
    xact("rd40", 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'h0, 0);

    // 2: full-word store then load
    xact("st10", 1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678, 32'h1234_5678, 0);
    xact("ld10", 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h1234_5678, 0);

    // 3: byte merge and zero byte-enable store
    xact("st20", 1'b1, 32'h0000_0020, 4'hF, 32'hAABB_CCDD, 32'hAABB_CCDD, 0);
    xact("mrg20", 1'b1, 32'h0000_0020, 4'b0101, 32'h1122_3344, 32'hAA22_CC44, 0);
    xact("ld20", 1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'hAA22_CC44, 0);
    xact("be0", 1'b1, 32'h0000_0020, 4'b0000, 32'hFFFF_FFFF, 32'hAA22_CC44, 0);
    xact("ld20b", 1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'hAA22_CC44, 0);
    xact("mrg_hi", 1'b1, 32'h0000_0022, 4'b1010, 32'h5566_7788, 32'h5522_7744, 0);

    // 4: upper address bits wrap, low two bits ignored
    xact("st1004", 1'b1, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    xact("ld4", 1'b0, 32'h0000_0004, 4'h0, 32'h0, 32'hDEAD_BEEF, 0);
    xact("ld7", 1'b0, 32'h0000_0007, 4'h0, 32'h0, 32'hDEAD_BEEF, 0);

    // 5: response backpressure with a stray request offered
    xact("bp", 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h1234_5678, 5);
    xact("bp_ld", 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h1234_5678, 0);

    // 6: reset one cycle after accepting a store
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0030;
    req_be    = 4'hF;
    req_wdata = 32'h5555_5555;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      check("abort/rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort/req_ready", 32'(req_ready), 32'd1);
    end
    xact("ld30", 1'b0, 32'h0000_0030, 4'h0, 32'h0, 32'h0, 0);
    xact("ld10_clr", 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends with a summary.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
